// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit state encoding, command bytes and
// the time-to-cycle conversion used to size the protocol timers.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_SHIFT,
        ST_ACK,
        ST_RECOVER
    } ps2_tx_state_e;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_RESP_ACK     = 8'hFA;

    localparam int unsigned PS2_CNT_W = 19;

    // Cycles for 'amount' units of time, where per_second is 1e6 for us or 1e3 for ms.
    function automatic int unsigned time_to_cycles(input int unsigned clk_hz,
                                                   input int unsigned amount,
                                                   input int unsigned per_second);
        longint unsigned product;
        product = 64'(clk_hz) * 64'(amount);
        return 32'(product / 64'(per_second));
    endfunction

    function automatic logic odd_parity(input logic [7:0] value);
        return ~^value;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for one PS/2 line with a falling-edge strobe
// (one cycle where the previous synchronised level was 1 and the current is 0).
module ps2_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic fall
);

    logic meta;
    logic prev;

    always_ff @(posedge clk) begin
        // NOTE: flops reset to 1 (idle bus) so leaving reset never looks like a falling edge.
        if (!rst_n) begin
            meta  <= 1'b1;
            level <= 1'b1;
            prev  <= 1'b1;
        end else begin
            meta  <= pin;
            level <= meta;
            prev  <= level;
        end
    end

    assign fall = prev & ~level;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter with open-drain pull-down enables.
// Optional macro PS2_TX_RETRY_EN: retry a NACKed or timed-out byte up to MAX_RETRY times.
module ps2_host_tx #(
    parameter int unsigned CLK_HZ            = 25_000_000,
    parameter int unsigned INHIBIT_US        = 100,
    parameter int unsigned START_TIMEOUT_MS  = 15,
    parameter int unsigned PACKET_TIMEOUT_MS = 2,
    parameter int unsigned MAX_RETRY         = 2
) (
    input  logic       CLK_25M,
    input  logic       Reset_N,
    input  logic       Key_Clk,
    input  logic       Key_Data,
    input  logic [7:0] Tx_Data,
    input  logic       Tx_Valid,
    output logic       Tx_Ready,
    output logic       Key_Clk_Drive_Low,
    output logic       Key_Data_Drive_Low,
    output logic       Tx_Busy,
    output logic       Tx_Done,
    output logic       Tx_Error
);

    import ps2_pkg::*;

    localparam int unsigned INHIBIT_CYC = time_to_cycles(CLK_HZ, INHIBIT_US, 1_000_000);
    localparam int unsigned START_CYC   = time_to_cycles(CLK_HZ, START_TIMEOUT_MS, 1_000);
    localparam int unsigned PACKET_CYC  = time_to_cycles(CLK_HZ, PACKET_TIMEOUT_MS, 1_000);

    localparam logic [PS2_CNT_W-1:0] INHIBIT_LAST = PS2_CNT_W'(INHIBIT_CYC - 1);
    localparam logic [PS2_CNT_W-1:0] START_LAST   = PS2_CNT_W'(START_CYC - 1);
    localparam logic [PS2_CNT_W-1:0] PACKET_LAST  = PS2_CNT_W'(PACKET_CYC - 1);

`ifdef PS2_TX_RETRY_EN
    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);
`else
    // Without retries every failure is final, whatever MAX_RETRY says.
    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY * 0);
`endif

    ps2_tx_state_e        state;
    logic [8:0]           frame;
    logic [8:0]           shift;
    logic [3:0]           bit_cnt;
    logic [PS2_CNT_W-1:0] cnt;
    logic [3:0]           attempt;
    logic                 failed;

    logic clk_level, clk_fall, data_level;

    ps2_line_sync u_clk_sync (
        .clk   (CLK_25M),
        .rst_n (Reset_N),
        .pin   (Key_Clk),
        .level (clk_level),
        .fall  (clk_fall)
    );

    ps2_line_sync u_data_sync (
        .clk   (CLK_25M),
        .rst_n (Reset_N),
        .pin   (Key_Data),
        .level (data_level),
        .fall  ()
    );

    always_ff @(posedge CLK_25M) begin
        if (!Reset_N) begin
            state              <= ST_IDLE;
            frame              <= '0;
            shift              <= '0;
            bit_cnt            <= '0;
            cnt                <= '0;
            attempt            <= '0;
            failed             <= 1'b0;
            Tx_Ready           <= 1'b1;
            Tx_Busy            <= 1'b0;
            Key_Clk_Drive_Low  <= 1'b0;
            Key_Data_Drive_Low <= 1'b0;
            Tx_Done            <= 1'b0;
            Tx_Error           <= 1'b0;
        end else begin
            Tx_Done  <= 1'b0;
            Tx_Error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Tx_Valid) begin
                        frame             <= {odd_parity(Tx_Data), Tx_Data};
                        shift             <= {odd_parity(Tx_Data), Tx_Data};
                        bit_cnt           <= '0;
                        cnt               <= '0;
                        attempt           <= '0;
                        failed            <= 1'b0;
                        Key_Clk_Drive_Low <= 1'b1;
                        Tx_Ready          <= 1'b0;
                        Tx_Busy           <= 1'b1;
                        state             <= ST_INHIBIT;
                    end
                end

                ST_INHIBIT: begin
                    if (cnt == INHIBIT_LAST) begin
                        Key_Clk_Drive_Low  <= 1'b0;
                        Key_Data_Drive_Low <= 1'b1;
                        cnt                <= '0;
                        state              <= ST_RTS;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // The first device edge clocks out the start bit; the host answers with bit 0.
                ST_RTS: begin
                    if (clk_fall) begin
                        Key_Data_Drive_Low <= ~shift[0];
                        shift              <= {1'b1, shift[8:1]};
                        bit_cnt            <= 4'd1;
                        cnt                <= '0;
                        state              <= ST_SHIFT;
                    end else if (cnt == START_LAST) begin
                        Key_Data_Drive_Low <= 1'b0;
                        failed             <= 1'b1;
                        cnt                <= '0;
                        state              <= ST_RECOVER;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Ones fill from the top, so the tenth edge naturally releases data (stop bit).
                ST_SHIFT: begin
                    if (cnt == PACKET_LAST) begin
                        Key_Data_Drive_Low <= 1'b0;
                        failed             <= 1'b1;
                        cnt                <= '0;
                        state              <= ST_RECOVER;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (clk_fall) begin
                            Key_Data_Drive_Low <= ~shift[0];
                            shift              <= {1'b1, shift[8:1]};
                            bit_cnt            <= bit_cnt + 1'b1;
                            if (bit_cnt == 4'd9) begin
                                state <= ST_ACK;
                            end
                        end
                    end
                end

                // Packet timer keeps running from SHIFT: the limit covers first edge to ack.
                ST_ACK: begin
                    if (cnt == PACKET_LAST) begin
                        failed <= 1'b1;
                        cnt    <= '0;
                        state  <= ST_RECOVER;
                    end else if (clk_fall) begin
                        failed <= data_level;
                        cnt    <= '0;
                        state  <= ST_RECOVER;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_RECOVER: begin
                    if (clk_level && data_level) begin
                        if (failed && attempt != RETRY_LIMIT) begin
                            attempt           <= attempt + 1'b1;
                            failed            <= 1'b0;
                            shift             <= frame;
                            bit_cnt           <= '0;
                            cnt               <= '0;
                            Key_Clk_Drive_Low <= 1'b1;
                            state             <= ST_INHIBIT;
                        end else begin
                            Tx_Done  <= ~failed;
                            Tx_Error <= failed;
                            Tx_Ready <= 1'b1;
                            Tx_Busy  <= 1'b0;
                            state    <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    Key_Clk_Drive_Low  <= 1'b0;
                    Key_Data_Drive_Low <= 1'b0;
                    Tx_Ready           <= 1'b1;
                    Tx_Busy            <= 1'b0;
                    state              <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a PS/2 device model clocks the frame out and
// compares every line bit and outcome against scoreboard queues.
module tb_ps2_host_tx;

    import ps2_pkg::*;

    localparam int unsigned TB_CLK_HZ = 2_000_000;
    localparam int INHIBIT_CYC = 100 * (TB_CLK_HZ / 1_000_000);
    localparam int START_CYC   = 15 * (TB_CLK_HZ / 1_000);
    localparam int HALF        = 12;
`ifdef PS2_TX_RETRY_EN
    localparam int NACK_ATTEMPTS = 3;
`else
    localparam int NACK_ATTEMPTS = 1;
`endif
    localparam logic [1:0] RES_DONE  = 2'b01;
    localparam logic [1:0] RES_ERROR = 2'b10;

    logic       CLK_25M = 1'b0;
    logic       Reset_N = 1'b0;
    logic [7:0] Tx_Data = 8'h00;
    logic       Tx_Valid = 1'b0;
    logic       Tx_Ready, Key_Clk_Drive_Low, Key_Data_Drive_Low, Tx_Busy, Tx_Done, Tx_Error;
    logic       bfm_clk = 1'b1;
    logic       bfm_data = 1'b1;
    logic       key_clk, key_data;

    assign key_clk  = bfm_clk & ~Key_Clk_Drive_Low;
    assign key_data = bfm_data & ~Key_Data_Drive_Low;

    logic       exp_bits[$];
    logic [1:0] exp_res[$];
    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int err_seen = 0;
    int inhibit_seen = 0;
    logic clk_low_q = 1'b0;

    ps2_host_tx #(
        .CLK_HZ            (TB_CLK_HZ),
        .INHIBIT_US        (100),
        .START_TIMEOUT_MS  (15),
        .PACKET_TIMEOUT_MS (2),
        .MAX_RETRY         (2)
    ) dut (
        .CLK_25M            (CLK_25M),
        .Reset_N            (Reset_N),
        .Key_Clk            (key_clk),
        .Key_Data           (key_data),
        .Tx_Data            (Tx_Data),
        .Tx_Valid           (Tx_Valid),
        .Tx_Ready           (Tx_Ready),
        .Key_Clk_Drive_Low  (Key_Clk_Drive_Low),
        .Key_Data_Drive_Low (Key_Data_Drive_Low),
        .Tx_Busy            (Tx_Busy),
        .Tx_Done            (Tx_Done),
        .Tx_Error           (Tx_Error)
    );

    always #20 CLK_25M = ~CLK_25M;

    always @(negedge CLK_25M) begin
        if (Tx_Done) done_seen <= done_seen + 1;
        if (Tx_Error) err_seen <= err_seen + 1;
        if (Key_Clk_Drive_Low && !clk_low_q) inhibit_seen <= inhibit_seen + 1;
        clk_low_q <= Key_Clk_Drive_Low;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK_25M);
    endtask

    task automatic push_frame(input logic [7:0] b);
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
        exp_bits.push_back(~^b);
        exp_bits.push_back(1'b1);
    endtask

    task automatic accept_checks(input string tag);
        check({tag, "_accept_clk_low"}, Key_Clk_Drive_Low, 1);
        check({tag, "_accept_busy"}, Tx_Busy, 1);
        check({tag, "_accept_ready"}, Tx_Ready, 0);
    endtask

    task automatic request(input string tag, input logic [7:0] b, input logic [1:0] res,
                           input bit keep);
        Tx_Data  = b;
        Tx_Valid = 1'b1;
        push_frame(b);
        exp_res.push_back(res);
        cyc(1);
        accept_checks(tag);
        if (!keep) Tx_Valid = 1'b0;
    endtask

    task automatic inhibit_phase(input string tag);
        int wait_n = 0;
        int len = 0;
        while (!Key_Clk_Drive_Low && wait_n < 10_000) begin cyc(1); wait_n++; end
        while (Key_Clk_Drive_Low && len < 10_000) begin cyc(1); len++; end
        check({tag, "_inhibit_len"}, len, INHIBIT_CYC);
        check({tag, "_rts_data_low"}, Key_Data_Drive_Low, 1);
    endtask

    // Device model: sample the line just before each falling edge; ack by pulling data
    // low ahead of the eleventh edge.
    task automatic device_frame(input int edges, input bit ack);
        logic exp_b;
        for (int k = 0; k < edges; k++) begin
            cyc(HALF);
            if (exp_bits.size() > 0) begin
                exp_b = exp_bits.pop_front();
                check($sformatf("line_bit%0d", k), key_data, exp_b);
            end
            if (k == 10 && ack) begin
                bfm_data = 1'b0;
                cyc(2);
            end
            bfm_clk = 1'b0;
            cyc(HALF);
            bfm_clk = 1'b1;
        end
        if (ack) begin
            cyc(HALF);
            bfm_data = 1'b1;
        end
    endtask

    task automatic wait_result(input string tag);
        int n = 0;
        logic [1:0] exp_r;
        while (!(Tx_Done || Tx_Error) && n < 50_000) begin cyc(1); n++; end
        exp_r = (exp_res.size() > 0) ? exp_res.pop_front() : 2'b00;
        check({tag, "_result"}, {Tx_Error, Tx_Done}, exp_r);
        check({tag, "_ready"}, Tx_Ready, 1);
        check({tag, "_busy"}, Tx_Busy, 0);
        check({tag, "_lines"}, {Key_Clk_Drive_Low, Key_Data_Drive_Low}, 0);
        cyc(1);
        check({tag, "_pulse_width"}, {Tx_Error, Tx_Done}, 0);
    endtask

    initial begin
        int n;
        int d0, e0, i0;

        // Reset state
        Reset_N = 1'b0;
        cyc(3);
        check("rst_ready", Tx_Ready, 1);
        check("rst_busy", Tx_Busy, 0);
        check("rst_lines", {Key_Clk_Drive_Low, Key_Data_Drive_Low}, 0);
        check("rst_pulses", {Tx_Error, Tx_Done}, 0);
        Reset_N = 1'b1;
        cyc(5);
        check("idle_ready", Tx_Ready, 1);

        // Set-LEDs command with acknowledge
        request("led", PS2_CMD_SET_LEDS, RES_DONE, 0);
        inhibit_phase("led");
        device_frame(11, 1);
        wait_result("led");

        // Back-to-back with Tx_Valid held: the byte must not be re-sampled while busy
        request("b2b0", 8'h00, RES_DONE, 1);
        Tx_Data = 8'h01;
        inhibit_phase("b2b0");
        device_frame(11, 1);
        push_frame(8'h01);
        exp_res.push_back(RES_DONE);
        wait_result("b2b0");
        accept_checks("b2b1");
        Tx_Valid = 1'b0;
        inhibit_phase("b2b1");
        device_frame(11, 1);
        wait_result("b2b1");

        // Device never clocks: start timeout
        request("tmo", PS2_CMD_ENABLE, RES_ERROR, 0);
        inhibit_phase("tmo");
        exp_bits.delete();
        n = 0;
        while (!(Tx_Done || Tx_Error) && n < START_CYC + 1000) begin cyc(1); n++; end
        check("tmo_window", (n >= START_CYC) && (n <= START_CYC + 3), 1);
        wait_result("tmo");

        // NACK in the ack slot
        d0 = done_seen; e0 = err_seen; i0 = inhibit_seen;
        request("nack", PS2_CMD_RESET, RES_ERROR, 0);
        for (int a = 0; a < NACK_ATTEMPTS; a++) begin
            if (a > 0) push_frame(PS2_CMD_RESET);
            inhibit_phase($sformatf("nack%0d", a));
            device_frame(11, 0);
        end
        wait_result("nack");
        cyc(2);
        check("nack_inhibit_phases", inhibit_seen - i0, NACK_ATTEMPTS);
        check("nack_error_pulses", err_seen - e0, 1);
        check("nack_done_pulses", done_seen - d0, 0);

        // Reset after the fourth data bit (bit 3 of 0x52 is 0, so data is held low)
        request("mid", 8'h52, RES_DONE, 0);
        inhibit_phase("mid");
        device_frame(4, 0);
        cyc(4);
        check("mid_data_low", Key_Data_Drive_Low, 1);
        exp_bits.delete();
        exp_res.delete();
        d0 = done_seen; e0 = err_seen;
        Reset_N = 1'b0;
        cyc(1);
        check("mid_rst_lines", {Key_Clk_Drive_Low, Key_Data_Drive_Low}, 0);
        check("mid_rst_ready", Tx_Ready, 1);
        Reset_N = 1'b1;
        cyc(50);
        check("mid_rst_no_pulse", (done_seen - d0) + (err_seen - e0), 0);

        // Device sends a scan code while idle; request is still accepted
        bfm_data = 1'b0;
        cyc(HALF);
        for (int k = 0; k < 3; k++) begin
            bfm_clk = 1'b0;
            cyc(HALF);
            bfm_clk = 1'b1;
            bfm_data = k[0];
            cyc(HALF);
        end
        check("scan_idle_ready", Tx_Ready, 1);
        check("scan_idle_busy", Tx_Busy, 0);
        request("scan", PS2_CMD_SET_LEDS, RES_DONE, 0);
        bfm_clk = 1'b1;
        bfm_data = 1'b1;
        inhibit_phase("scan");
        device_frame(11, 1);
        wait_result("scan");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

- Sends one byte from host to keyboard: PS/2 host-to-device command path (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable).
- Complements the existing PS/2 receive path (`Process_Keyboard`) and sits beside it in the calculator top.
- Runs on the 25 MHz system clock and drives the keyboard clock/data lines as open-drain pull-down enables; the top level builds the tristates.
- Reports line-level acknowledge, NACK or timeout, and flags the bus busy so the top can ignore receive-path traffic during a transmission.

## Interface
Parameters:
- CLK_HZ, 25_000_000, system clock frequency.
- INHIBIT_US, 100, time the host holds the clock low before request-to-send.
- START_TIMEOUT_MS, 15, maximum wait from request-to-send to the device's first falling clock.
- PACKET_TIMEOUT_MS, 2, maximum time from first falling clock to acknowledge.
- MAX_RETRY, 2, extra attempts (used only with PS2_TX_RETRY_EN).

Ports:
- CLK_25M  in  1  system clock.
- Reset_N  in  1  reset; one clock; reset is synchronous and active-low.
- Key_Clk  in  1  PS/2 clock pin level (asynchronous).
- Key_Data  in  1  PS/2 data pin level (asynchronous).
- Tx_Data  in  8  command byte.
- Tx_Valid  in  1  request; accepted when Tx_Valid && Tx_Ready.
- Tx_Ready  out  1  high only in IDLE.
- Key_Clk_Drive_Low  out  1  1 = pull the clock line low.
- Key_Data_Drive_Low  out  1  1 = pull the data line low.
- Tx_Busy  out  1  high in every state except IDLE.
- Tx_Done  out  1  one-cycle pulse on device acknowledge.
- Tx_Error  out  1  one-cycle pulse on NACK or timeout.

## Operation
- Key_Clk and Key_Data pass through 2-FF synchronisers.
- A falling edge of the synchronised clock is one cycle with prev=1 and cur=0.
- States:
  - IDLE: lines released, Tx_Ready=1. On accept, latch {odd parity, Tx_Data} into a 9-bit shift register, clear the bit counter, go to INHIBIT.
  - INHIBIT: Key_Clk_Drive_Low=1 for exactly INHIBIT_US×CLK_HZ/1e6 cycles (2500), then go to RTS.
  - RTS: release the clock, Key_Data_Drive_Low=1 (start bit). Wait for a falling edge, then go to SHIFT. A timeout counter runs from RTS entry.
  - SHIFT: on each falling edge drive the next bit, with Key_Data_Drive_Low = ~bit.
    - Edges 1–8 drive data bits 0–7, LSB first.
    - Edge 9 drives parity.
    - Edge 10 drives the stop bit (release data); go to ACK.
  - ACK: on the next falling edge sample synchronised Key_Data. Low means acknowledge; high means NACK. Go to RECOVER.
  - RECOVER: wait until both synchronised lines are high, then pulse Tx_Done or Tx_Error in the cycle of return to IDLE.
- Parity = ~^Tx_Data (odd). Example: 0xED gives 1, 0x01 gives 0.
- Timeouts:
  - No edge in RTS within START_TIMEOUT_MS (375_000 cycles): failure.
  - No acknowledge within PACKET_TIMEOUT_MS (50_000 cycles) from the first edge: failure.
  - On failure, release both lines immediately and go to RECOVER with the error recorded.
- Tx_Valid while busy is not accepted, and Tx_Data is not re-sampled.
- Device clock activity in IDLE is ignored.

## Timing
- Reset values: Tx_Ready=1, Tx_Busy=0, Key_Clk_Drive_Low=0, Key_Data_Drive_Low=0, Tx_Done=0, Tx_Error=0, state IDLE.
- Reset mid-operation releases both lines at the next clock edge.
- All outputs are registered.
- Key_Clk_Drive_Low rises 1 cycle after the accept cycle. Tx_Ready and Tx_Busy change in the same cycle.
- Data changes 3 cycles after the pin's falling edge (2 synchroniser cycles plus 1 register). This is well within the ≥5 µs half-period.
- Tx_Done and Tx_Error are never asserted together.
- A new request can be accepted in the cycle after the pulse.
- Counter width is 19 bits, sized for the largest timeout. It reloads on each state entry.

## Configuration
- PS2_TX_RETRY_EN defined:
  - On NACK or timeout, RECOVER returns to INHIBIT with the same latched byte instead of IDLE.
  - Up to MAX_RETRY extra attempts are made. Tx_Error pulses only after the last failure.
  - Tx_Busy stays high throughout.
- PS2_TX_RETRY_EN undefined: the first failure pulses Tx_Error and returns to IDLE.

## Structure
- Shared package ps2_pkg holds:
  - the state enum;
  - command constants PS2_CMD_SET_LEDS=8'hED, PS2_CMD_RESET=8'hFF, PS2_CMD_ENABLE=8'hF4, PS2_RESP_ACK=8'hFA;
  - the function converting µs/ms to cycles.
- One sub-module, ps2_line_sync: 2-FF synchroniser plus falling-edge detect, instantiated for Key_Clk and Key_Data. The receiver can reuse it.

## Test plan
- Send 0xED to a device BFM:
  - clock held low 2500 cycles;
  - BFM samples start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1;
  - BFM acks, giving one Tx_Done pulse and Tx_Ready=1.
- Send 0x00 then 0x01 back-to-back, with Tx_Valid held high throughout:
  - parity 1 then 0;
  - second byte accepted only after the first Tx_Done.
- BFM never clocks:
  - Tx_Error fires 375_000 cycles after RTS entry (plus recovery);
  - both drive-low outputs are 0 by then.
- BFM leaves data high in the ack slot:
  - without the macro, Tx_Error after 1 attempt;
  - with PS2_TX_RETRY_EN, 3 inhibit phases then a single Tx_Error.
- Assert Reset_N=0 after the 4th data bit: both drive-low outputs are 0 and Tx_Ready=1 next cycle, with no Done/Error pulse.
- Assert Tx_Valid while the BFM sends a scan code in IDLE: the request is accepted, and Tx_Busy rises 1 cycle after the accept.
